// File: rtl/dac_gain_pkg.sv
// Shared constants for the DAC gain SPI controller: frame layout, FSM state
// encodings and the round-robin pick helper.
package dac_gain_pkg;

  localparam int FRAME_W = 24;
  localparam int ADDR_W  = 4;
  localparam logic [3:0] CMD_WR_UPD = 4'h3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD       = 3'd1;
  localparam logic [2:0] ST_SHIFT      = 3'd2;
  localparam logic [2:0] ST_GAP        = 3'd3;
  localparam logic [2:0] ST_LDAC_WAIT  = 3'd4;
  localparam logic [2:0] ST_LDAC_PULSE = 3'd5;

  // Returns {found, idx}: first set bit of req at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic       found;
    logic [2:0] idx;
    int         j;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !found && req[j[2:0]]) begin
        found = 1'b1;
        idx   = j[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// 24-bit SPI mode-0 frame shifter, MSB first. A start strobe while idle drops
// ss_n and presents the MSB; SCK_HALF clk per sck half-period; ss_n rises one
// half-period after the last falling edge. Synchronous active-low reset
// abandons any frame in flight on the same edge.
module spi_frame_tx
  import dac_gain_pkg::*;
#(
  parameter int SCK_HALF = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               ss_n,
  output logic               sck,
  output logic               mosi,
  output logic               last,
  output logic               done
);

  localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic             active;
  logic             tail;
  logic [DIV_W-1:0] div;
  logic [5:0]       edges;
  logic [FRAME_W-2:0] shreg;
  logic             tick;

  assign tick = (div == DIV_W'(SCK_HALF - 1));
  // last: the edge producing the final falling sck; done: the edge raising ss_n.
  assign last = active && !tail && tick && (edges == 6'(2*FRAME_W - 1));
  assign done = active && tail && tick;

  // Half-period divider, edge counter and shift register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active <= 1'b0;
      tail   <= 1'b0;
      div    <= '0;
      edges  <= '0;
      shreg  <= '0;
      ss_n   <= 1'b1;
      sck    <= 1'b0;
      mosi   <= 1'b0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        tail   <= 1'b0;
        div    <= '0;
        edges  <= '0;
        ss_n   <= 1'b0;
        mosi   <= frame[FRAME_W-1];
        shreg  <= frame[FRAME_W-2:0];
      end
    end else if (!tick) begin
      div <= div + 1'b1;
    end else begin
      div <= '0;
      if (tail) begin
        ss_n   <= 1'b1;
        mosi   <= 1'b0;
        active <= 1'b0;
        tail   <= 1'b0;
      end else if (!edges[0]) begin
        sck   <= 1'b1;
        edges <= edges + 1'b1;
      end else begin
        sck   <= 1'b0;
        edges <= edges + 1'b1;
        if (edges == 6'(2*FRAME_W - 1)) begin
          tail <= 1'b1;
        end else begin
          mosi  <= shreg[FRAME_W-2];
          shreg <= {shreg[FRAME_W-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/dac_gain_spi_ctrl.sv
// N-channel DAC gain controller. Registers gain/limit requests, accepts a
// gain only when strictly below the channel's current limit, and sends each
// accepted gain as a 24-bit SPI frame {cmd, addr, data}, round-robin across
// channels, followed by an LDAC pulse.
// Build option LIMIT_CLAMP_EN: an over-limit request stores limit-1 (0 when
// the limit is 0) and is still sent; gain_rej pulses either way.
module dac_gain_spi_ctrl
  import dac_gain_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDR  = {4'h8, 4'h1},
  parameter logic [NUM_CH*DATA_W-1:0] GAIN_RST = {16'h0000, 16'h6050},
  parameter int SCK_HALF = 1,
  parameter int LDAC_DLY = 11,
  parameter int LDAC_LEN = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        gain_wr,
  input  logic [NUM_CH*DATA_W-1:0] gain_in,
  input  logic [NUM_CH-1:0]        limit_wr,
  input  logic [NUM_CH*DATA_W-1:0] limit_in,
  output logic [NUM_CH-1:0]        gain_rej,
  output logic                     busy,
  output logic                     spi_ready,
  output logic                     ss_n,
  output logic                     sck,
  output logic                     mosi,
  output logic                     ldac_n
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]             gain_wr_q, limit_wr_q;
  logic [NUM_CH-1:0][DATA_W-1:0] gain_in_q, limit_in_q;
  logic [NUM_CH-1:0][DATA_W-1:0] gain_q, limit_q;
  logic [NUM_CH-1:0]             pending, acc, rej, set, clr;
`ifdef LIMIT_CLAMP_EN
  logic [NUM_CH-1:0][DATA_W-1:0] clamp;
`endif

  logic [2:0]         state;
  logic [CH_W-1:0]    rr, pick_ch;
  logic [3:0]         pick;
  logic               start;
  logic [15:0]        data16;
  logic [FRAME_W-1:0] frame;
  logic [15:0]        tmr;
  logic               tx_last, tx_done;

  // Single input register stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gain_wr_q  <= '0;
      limit_wr_q <= '0;
      gain_in_q  <= '0;
      limit_in_q <= '0;
    end else begin
      gain_wr_q  <= gain_wr;
      limit_wr_q <= limit_wr;
      gain_in_q  <= gain_in;
      limit_in_q <= limit_in;
    end
  end

  // Limit compare against the stored (old) limit.
  always_comb begin
    acc = '0;
    rej = '0;
    set = '0;
`ifdef LIMIT_CLAMP_EN
    clamp = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c] = gain_wr_q[c] && (gain_in_q[c] < limit_q[c]);
      rej[c] = gain_wr_q[c] && !acc[c];
`ifdef LIMIT_CLAMP_EN
      clamp[c] = (limit_q[c] == '0) ? '0 : limit_q[c] - 1'b1;
      set[c]   = gain_wr_q[c];
`else
      set[c]   = acc[c];
`endif
    end
  end

  // Per-channel gain/limit registers and pending flags; a new accept wins
  // over the clear issued when that channel is launched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gain_q   <= GAIN_RST;
      limit_q  <= '1;
      pending  <= '0;
      gain_rej <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        gain_rej[c] <= rej[c];
        if (limit_wr_q[c]) limit_q[c] <= limit_in_q[c];
        if (acc[c]) gain_q[c] <= gain_in_q[c];
`ifdef LIMIT_CLAMP_EN
        else if (rej[c]) gain_q[c] <= clamp[c];
`endif
        pending[c] <= set[c] | (pending[c] & ~clr[c]);
      end
    end
  end

  // Round-robin pick and frame assembly for the channel being launched.
  always_comb begin
    pick    = rr_pick(8'(pending), 3'(rr), NUM_CH);
    pick_ch = CH_W'(pick[2:0]);
    start   = (state == ST_IDLE) && pick[3];
    clr     = '0;
    if (start) clr[pick_ch] = 1'b1;
    data16 = '0;
    data16[15 -: DATA_W] = gain_q[pick_ch];
    frame = {CMD_WR_UPD, CH_ADDR[int'(pick_ch)*ADDR_W +: ADDR_W], data16};
  end

  // Sequencer: launch, follow the shifter, then LDAC delay and pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      rr     <= '0;
      tmr    <= '0;
      ldac_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_LOAD;
          rr    <= (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + 1'b1;
        end
        ST_LOAD:  state <= ST_SHIFT;
        ST_SHIFT: if (tx_last) state <= ST_GAP;
        ST_GAP: if (tx_done) begin
          state <= ST_LDAC_WAIT;
          tmr   <= '0;
        end
        ST_LDAC_WAIT: if (tmr == 16'(LDAC_DLY - 1)) begin
          state  <= ST_LDAC_PULSE;
          ldac_n <= 1'b0;
          tmr    <= '0;
        end else begin
          tmr <= tmr + 1'b1;
        end
        ST_LDAC_PULSE: if (tmr == 16'(LDAC_LEN - 1)) begin
          state  <= ST_IDLE;
          ldac_n <= 1'b1;
          tmr    <= '0;
        end else begin
          tmr <= tmr + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_frame_tx #(.SCK_HALF(SCK_HALF)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .frame (frame),
    .ss_n  (ss_n),
    .sck   (sck),
    .mosi  (mosi),
    .last  (tx_last),
    .done  (tx_done)
  );

  assign spi_ready = ss_n;
  assign busy      = (state != ST_IDLE) || (|pending);

endmodule

// File: tb/tb_dac_gain_spi_ctrl.sv
// Bench for dac_gain_spi_ctrl: default 2-channel instance plus a 4-channel,
// 12-bit, SCK_HALF=3 instance. Stimulus pushes expected frames into queues;
// SPI monitors decode frames and check them plus ss_n/LDAC timing.
module tb_dac_gain_spi_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  gain_wr_a = '0, limit_wr_a = '0, gain_rej_a;
  logic [31:0] gain_in_a = '0, limit_in_a = '0;
  logic        busy_a, spi_ready_a, ss_n_a, sck_a, mosi_a, ldac_n_a;

  logic [3:0]  gain_wr_b = '0, limit_wr_b = '0, gain_rej_b;
  logic [47:0] gain_in_b = '0, limit_in_b = '0;
  logic        busy_b, spi_ready_b, ss_n_b, sck_b, mosi_b, ldac_n_b;

  dac_gain_spi_ctrl u_a (
    .clk(clk), .rstn(rstn), .gain_wr(gain_wr_a), .gain_in(gain_in_a),
    .limit_wr(limit_wr_a), .limit_in(limit_in_a), .gain_rej(gain_rej_a),
    .busy(busy_a), .spi_ready(spi_ready_a), .ss_n(ss_n_a), .sck(sck_a),
    .mosi(mosi_a), .ldac_n(ldac_n_a)
  );

  dac_gain_spi_ctrl #(
    .NUM_CH(4), .DATA_W(12), .CH_ADDR(16'h4321), .GAIN_RST(48'h0), .SCK_HALF(3)
  ) u_b (
    .clk(clk), .rstn(rstn), .gain_wr(gain_wr_b), .gain_in(gain_in_b),
    .limit_wr(limit_wr_b), .limit_in(limit_in_b), .gain_rej(gain_rej_b),
    .busy(busy_b), .spi_ready(spi_ready_b), .ss_n(ss_n_b), .sck(sck_b),
    .mosi(mosi_b), .ldac_n(ldac_n_b)
  );

  int vecs = 0;
  int errs = 0;
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];

  // Monitor state (instance A)
  int bits_a = 0, span_a = 0, wcnt_a = 0, lcnt_a = 0;
  logic psck_a = 1'b0, pss_a = 1'b1, arm_a = 1'b0;
  logic [23:0] sh_a = '0;
  // Monitor state (instance B)
  int rises_b = 0, per_b = 0;
  logic psck_b = 1'b0, pss_b = 1'b1;
  logic [23:0] sh_b = '0;

  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task mon_a();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bits_a = 0; arm_a = 1'b0; psck_a = 1'b0; pss_a = 1'b1;
      end else begin
        if (!pss_a) span_a++;
        if (sck_a && !psck_a) begin
          sh_a = {sh_a[22:0], mosi_a};
          bits_a++;
        end
        if (!ss_n_a && pss_a) begin
          bits_a = 0; span_a = 0;
        end
        if (ss_n_a && !pss_a) begin
          chk("frame_bits_a", bits_a, 24);
          if (q_a.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_frame_a: got 0x%06h, want none", sh_a);
          end else begin
            chk("frame_a", sh_a, q_a.pop_front());
          end
          chk("ss_low_span_a", span_a, 49);
          arm_a = 1'b1; wcnt_a = 0; lcnt_a = 0;
        end else if (arm_a) begin
          if (ldac_n_a) begin
            if (lcnt_a == 0) wcnt_a++;
            else begin
              chk("ldac_width_a", lcnt_a, 5);
              arm_a = 1'b0;
            end
          end else begin
            if (lcnt_a == 0) begin
              wcnt_a++;
              chk("ldac_delay_a", wcnt_a, 11);
            end
            lcnt_a++;
          end
        end
        psck_a = sck_a; pss_a = ss_n_a;
      end
    end
  endtask

  task mon_b();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rises_b = 0; psck_b = 1'b0; pss_b = 1'b1;
      end else begin
        per_b++;
        if (!ss_n_b && pss_b) begin
          rises_b = 0; per_b = 0;
        end
        if (sck_b && !psck_b) begin
          sh_b = {sh_b[22:0], mosi_b};
          if (rises_b > 0) chk("sck_period_b", per_b, 6);
          rises_b++; per_b = 0;
        end
        if (ss_n_b && !pss_b) begin
          chk("sck_rises_b", rises_b, 24);
          if (q_b.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_frame_b: got 0x%06h, want none", sh_b);
          end else begin
            chk("frame_b", sh_b, q_b.pop_front());
          end
        end
        psck_b = sck_b; pss_b = ss_n_b;
      end
    end
  endtask

  task wr_a(input logic [1:0] gw, input logic [31:0] gv, input logic [1:0] lw,
            input logic [31:0] lv, input logic [1:0] rej, input string nm);
    @(negedge clk);
    gain_wr_a = gw; gain_in_a = gv; limit_wr_a = lw; limit_in_a = lv;
    @(negedge clk);
    gain_wr_a = '0; limit_wr_a = '0;
    @(negedge clk);
    chk(nm, gain_rej_a, rej);
  endtask

  task wait_idle(input int which);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (((which == 0) ? busy_a : busy_b) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk((which == 0) ? "idle_a" : "idle_b", (which == 0) ? busy_a : busy_b, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    logic saw;
    int n;
    fork
      mon_a();
      mon_b();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ss_sck_mosi_a", {ss_n_a, sck_a, mosi_a}, 3'b100);
    chk("rst_ldac_ready_busy_a", {ldac_n_a, spi_ready_a, busy_a}, 3'b110);
    chk("rst_rej_a", gain_rej_a, 0);
    chk("rst_outs_b", {ss_n_b, sck_b, mosi_b, ldac_n_b, spi_ready_b, busy_b}, 6'b100110);
    chk("rst_rej_b", gain_rej_b, 0);
    rstn = 1'b1;

    // 1: basic frame on ch0
    q_a.push_back(24'h311234);
    wr_a(2'b01, 32'h0000_1234, 2'b00, 32'h0, 2'b00, "rej_t1");
    wait_idle(0);

    // 2: limit boundaries on ch1
    wr_a(2'b10, 32'hFFFF_0000, 2'b00, 32'h0, 2'b10, "rej_ffff_vs_allones");
`ifdef LIMIT_CLAMP_EN
    q_a.push_back(24'h38FFFE);
`endif
    wait_idle(0);
    wr_a(2'b00, 32'h0, 2'b10, 32'h0800_0000, 2'b00, "rej_limit_only");
    wait_idle(0);
`ifdef LIMIT_CLAMP_EN
    q_a.push_back(24'h3807FF);
`endif
    wr_a(2'b10, 32'h0900_0000, 2'b00, 32'h0, 2'b10, "rej_over_limit");
    wait_idle(0);
`ifdef LIMIT_CLAMP_EN
    q_a.push_back(24'h3807FF);
`endif
    wr_a(2'b10, 32'h0800_0000, 2'b00, 32'h0, 2'b10, "rej_equal_limit");
    wait_idle(0);
    q_a.push_back(24'h3807FF);
    wr_a(2'b10, 32'h07FF_0000, 2'b00, 32'h0, 2'b00, "rej_below_limit");
    wait_idle(0);
    wr_a(2'b00, 32'h0, 2'b10, 32'hFFFF_0000, 2'b00, "rej_limit_restore1");
    wait_idle(0);

    // 3: simultaneous writes, then round-robin order with rr on ch1
    q_a.push_back(24'h310AAA);
    q_a.push_back(24'h380BBB);
    wr_a(2'b11, 32'h0BBB_0AAA, 2'b00, 32'h0, 2'b00, "rej_both");
    wait_idle(0);
    q_a.push_back(24'h310123);
    wr_a(2'b01, 32'h0000_0123, 2'b00, 32'h0, 2'b00, "rej_rr_prep");
    wait_idle(0);
    q_a.push_back(24'h380456);
    q_a.push_back(24'h310789);
    wr_a(2'b11, 32'h0456_0789, 2'b00, 32'h0, 2'b00, "rej_rr_both");
    wait_idle(0);

    // Same-cycle limit and gain: old limit applies
    q_a.push_back(24'h310200);
    wr_a(2'b01, 32'h0000_0200, 2'b01, 32'h0000_0100, 2'b00, "rej_old_limit");
    wait_idle(0);
`ifdef LIMIT_CLAMP_EN
    q_a.push_back(24'h3100FF);
`endif
    wr_a(2'b01, 32'h0000_0100, 2'b00, 32'h0, 2'b01, "rej_new_limit");
    wait_idle(0);
    wr_a(2'b00, 32'h0, 2'b01, 32'h0000_FFFF, 2'b00, "rej_limit_restore0");
    wait_idle(0);

    // 4: rewrite of ch0 while its frame is shifting
    q_a.push_back(24'h311111);
    q_a.push_back(24'h312222);
    wr_a(2'b01, 32'h0000_1111, 2'b00, 32'h0, 2'b00, "rej_t4a");
    n = 0;
    while (!(!ss_n_a && bits_a >= 5 && bits_a < 24) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("t4_reach_shift", n < 200, 1);
    wr_a(2'b01, 32'h0000_2222, 2'b00, 32'h0, 2'b00, "rej_t4b");
    wait_idle(0);

    // 5: reset at bit 10 of a frame
    wr_a(2'b01, 32'h0000_5A5A, 2'b00, 32'h0, 2'b00, "rej_t5");
    n = 0;
    while (!(!ss_n_a && bits_a == 10) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("t5_reach_bit10", n < 200, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_ss_sck", {ss_n_a, sck_a}, 2'b10);
    chk("abort_gain_rst", u_a.gain_q, 32'h0000_6050);
    chk("abort_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!ldac_n_a) saw = 1'b1;
    end
    chk("abort_no_ldac", saw, 0);

    // 6: wide instance, ch3, SCK_HALF=3, 12-bit data left-justified
    q_b.push_back(24'h34ABC0);
    @(negedge clk);
    gain_wr_b = 4'b1000; gain_in_b = {12'hABC, 36'h0};
    @(negedge clk);
    gain_wr_b = '0;
    wait_idle(1);

    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
